vit_pmu: RTL and testbench

Parametrised path-metric unit (PMU) for hard-decision, rate-1/2 Viterbi decoding with any constraint length K from 3 to 7 and configurable generator polynomials. It sits between the symbol input and the survivor (trellis) memory. Each accepted symbol pair triggers one trellis step: branch metric, add-compare-select and metric normalisation. Its outputs are the per-state survivor selection word and validity mask, with optional best-state tracking for best-state-start traceback.

---
 rtl/vit_pmu.sv | 130 +++++++++++++
 tb/tb_vit_pmu.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vit_pmu.sv
// vit_pmu: hard-decision rate-1/2 Viterbi path-metric unit (branch metric, ACS, normalisation).
// Define VIT_PMU_BEST_STATE_EN to enable best_state/best_metric tracking; otherwise both are tied to 0.
module vit_pmu #(
  parameter int K = 4,
  parameter logic [K-1:0] G0 = 4'b1111,
  parameter logic [K-1:0] G1 = 4'b1101,
  parameter int MW = 8,
  localparam int NS = 1 << (K - 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          in_valid,
  input  logic [1:0]    d_in,
  output logic          out_valid,
  output logic [NS-1:0] sel,
  output logic [NS-1:0] valid_mask,
  output logic          norm_event,
  output logic [K-2:0]  best_state,
  output logic [MW-1:0] best_metric
);

  // All-ones marks an unreachable state, so reachable metrics stop one below it.
  localparam logic [MW-1:0] PM_INV  = '1;
  localparam logic [MW-1:0] PM_SAT  = {{(MW-1){1'b1}}, 1'b0};
  localparam logic [MW-1:0] PM_HALF = {1'b1, {(MW-1){1'b0}}};
  localparam logic [NS-1:0][MW-1:0] PM_RST = {{((NS-1)*MW){1'b1}}, {MW{1'b0}}};

  logic [NS-1:0][MW-1:0] pm;
  logic [NS-1:0][MW-1:0] pm_nxt;
  logic [NS-1:0]         sel_nxt;
  logic [NS-1:0]         valid_nxt;
  logic                  norm;

  function automatic logic [1:0] branch_metric(input logic [K-2:0] nstate, input logic bit_j,
                                                input logic [1:0] sym);
    logic [K-1:0] path;
    logic c0, c1;
    path = {nstate, bit_j};
    c0 = ^(G0 & path);
    c1 = ^(G1 & path);
    return {1'b0, c0 ^ sym[1]} + {1'b0, c1 ^ sym[0]};
  endfunction

  always_comb begin
    norm = 1'b1;
    for (int s = 0; s < NS; s++) begin
      if (valid_mask[s] && !pm[s][MW-1]) norm = 1'b0;
    end
  end

  for (genvar n = 0; n < NS; n++) begin : g_acs
    localparam logic [K-2:0] NST = (K-1)'(n);
    localparam logic [K-2:0] P0  = {NST[K-3:0], 1'b0};
    localparam logic [K-2:0] P1  = {NST[K-3:0], 1'b1};
    logic          v0, v1, pick1;
    logic [MW:0]   cand0, cand1, win;
    logic [MW-1:0] sat;

    assign v0    = valid_mask[P0];
    assign v1    = valid_mask[P1];
    assign cand0 = {1'b0, pm[P0]} + (MW+1)'(branch_metric(NST, 1'b0, d_in));
    assign cand1 = {1'b0, pm[P1]} + (MW+1)'(branch_metric(NST, 1'b1, d_in));
    // Ties and a lone even predecessor both resolve to the even path.
    assign pick1 = v1 & (~v0 | (cand1 < cand0));
    assign win   = pick1 ? cand1 : cand0;
    assign sat   = (win > {1'b0, PM_SAT}) ? PM_SAT : win[MW-1:0];
    assign sel_nxt[n]   = pick1;
    assign valid_nxt[n] = v0 | v1;
    assign pm_nxt[n]    = ~(v0 | v1) ? PM_INV : (norm ? sat - PM_HALF : sat);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pm         <= PM_RST;
      valid_mask <= NS'(1);
      sel        <= '0;
      out_valid  <= 1'b0;
      norm_event <= 1'b0;
    end else if (!enable) begin
      pm         <= PM_RST;
      valid_mask <= NS'(1);
      sel        <= '0;
      out_valid  <= 1'b0;
      norm_event <= 1'b0;
    end else begin
      out_valid  <= in_valid;
      norm_event <= in_valid & norm;
      if (in_valid) begin
        pm         <= pm_nxt;
        valid_mask <= valid_nxt;
        sel        <= sel_nxt;
      end
    end
  end

`ifdef VIT_PMU_BEST_STATE_EN
  logic [K-2:0]  min_idx;
  logic [MW-1:0] min_val;

  // Searches the metrics about to be registered so the result lines up with sel.
  always_comb begin
    min_idx = '0;
    min_val = PM_INV;
    for (int s = 0; s < NS; s++) begin
      if (valid_nxt[s] && (pm_nxt[s] < min_val)) begin
        min_idx = (K-1)'(s);
        min_val = pm_nxt[s];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_state  <= '0;
      best_metric <= '0;
    end else if (!enable) begin
      best_state  <= '0;
      best_metric <= '0;
    end else if (in_valid) begin
      best_state  <= min_idx;
      best_metric <= min_val;
    end
  end
`else
  assign best_state  = '0;
  assign best_metric = '0;
`endif

endmodule

// File: tb/tb_vit_pmu.sv
// tb_vit_pmu: scoreboard bench for vit_pmu, one K=4/MW=8 instance and one K=7/MW=5 instance.
module tb_vit_pmu;

`ifdef VIT_PMU_BEST_STATE_EN
  localparam bit BEST_EN = 1'b1;
`else
  localparam bit BEST_EN = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] sel;
    logic [63:0] mask;
    logic        norm;
    logic [5:0]  bs;
    logic [7:0]  bmet;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_a = 1'b1, iv_a = 1'b0, en_b = 1'b1, iv_b = 1'b0;
  logic [1:0] d_a = 2'b00, d_b = 2'b00;

  logic       ov_a, ne_a, ov_b, ne_b;
  logic [7:0] sel_a, vm_a, bm_a;
  logic [2:0] bs_a;
  logic [63:0] sel_b, vm_b;
  logic [5:0] bs_b;
  logic [4:0] bm_b;

  int vectors = 0;
  int miscompares = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb, eb_last;

  int mk[2]  = '{4, 7};
  int mg0[2] = '{15, 7'b1111001};
  int mg1[2] = '{13, 7'b1011011};
  int mmw[2] = '{8, 5};
  int mpm[2][64];
  bit mval[2][64];
  int enc_st[2];

  vit_pmu u_a (
    .clk(clk), .rst(rst), .enable(en_a), .in_valid(iv_a), .d_in(d_a),
    .out_valid(ov_a), .sel(sel_a), .valid_mask(vm_a), .norm_event(ne_a),
    .best_state(bs_a), .best_metric(bm_a)
  );

  vit_pmu #(.K(7), .G0(7'b1111001), .G1(7'b1011011), .MW(5)) u_b (
    .clk(clk), .rst(rst), .enable(en_b), .in_valid(iv_b), .d_in(d_b),
    .out_valid(ov_b), .sel(sel_b), .valid_mask(vm_b), .norm_event(ne_b),
    .best_state(bs_b), .best_metric(bm_b)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int i);
    for (int s = 0; s < 64; s++) begin
      mval[i][s] = 1'b0;
      mpm[i][s]  = (1 << mmw[i]) - 1;
    end
    mval[i][0] = 1'b1;
    mpm[i][0]  = 0;
  endtask

  // Reference trellis step: Hamming branch metrics, ACS, saturation, then normalisation.
  task automatic model_step(input int i, input logic [1:0] d, output exp_t e);
    int k, ns, inv, half, best_v, best_s;
    int nxt[64];
    bit nv[64];
    bit nrm;
    k = mk[i];
    ns = 1 << (k - 1);
    inv = (1 << mmw[i]) - 1;
    half = 1 << (mmw[i] - 1);
    nrm = 1'b1;
    for (int s = 0; s < ns; s++)
      if (mval[i][s] && mpm[i][s] < half) nrm = 1'b0;
    e = '0;
    for (int n = 0; n < ns; n++) begin
      int u, val;
      int cnd[2];
      bit v[2];
      bit take1;
      u = (n >> (k - 2)) & 1;
      for (int j = 0; j < 2; j++) begin
        int p, full;
        bit b0, b1;
        p = ((n << 1) & (ns - 1)) | j;
        full = (u << (k - 1)) | p;
        b0 = ^(mg0[i] & full);
        b1 = ^(mg1[i] & full);
        cnd[j] = mpm[i][p] + int'(b0 != d[1]) + int'(b1 != d[0]);
        v[j] = mval[i][p];
      end
      if (!v[0] && !v[1]) begin
        nv[n] = 1'b0;
        nxt[n] = inv;
      end else begin
        take1 = v[1] && (!v[0] || cnd[1] < cnd[0]);
        e.sel[n] = take1;
        val = take1 ? cnd[1] : cnd[0];
        if (val > inv - 1) val = inv - 1;
        if (nrm) val = val - half;
        nv[n] = 1'b1;
        nxt[n] = val;
      end
    end
    best_v = inv;
    best_s = 0;
    for (int n = 0; n < ns; n++) begin
      mval[i][n] = nv[n];
      mpm[i][n]  = nxt[n];
      e.mask[n]  = nv[n];
      if (nv[n] && nxt[n] < best_v) begin
        best_v = nxt[n];
        best_s = n;
      end
    end
    e.norm = nrm;
    e.bs   = BEST_EN ? 6'(best_s) : 6'd0;
    e.bmet = BEST_EN ? 8'(best_v) : 8'd0;
  endtask

  task automatic encode(input int i, input bit u, output logic [1:0] d);
    int full;
    full = (int'(u) << (mk[i] - 1)) | enc_st[i];
    d = {^(mg0[i] & full), ^(mg1[i] & full)};
    enc_st[i] = (int'(u) << (mk[i] - 2)) | (enc_st[i] >> 1);
  endtask

  task automatic apply_stimulus(input int i, input logic [1:0] d);
    exp_t e;
    @(negedge clk);
    model_step(i, d, e);
    if (i == 0) begin
      en_a = 1'b1; iv_a = 1'b1; d_a = d;
      qa.push_back(e);
    end else begin
      en_b = 1'b1; iv_b = 1'b1; d_b = d;
      qb.push_back(e);
      eb_last = e;
    end
  endtask

  task automatic idle(input int i);
    @(negedge clk);
    if (i == 0) iv_a = 1'b0;
    else iv_b = 1'b0;
  endtask

  task automatic reset_all();
    @(posedge clk);
    #2;
    rst = 1'b0;
    iv_a = 1'b0; iv_b = 1'b0; en_a = 1'b1; en_b = 1'b1;
    qa.delete();
    qb.delete();
    model_reset(0);
    model_reset(1);
    enc_st = '{0, 0};
    eb_last = '0;
    eb_last.mask = 64'd1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (ov_a === 1'b1) begin
      if (qa.size() == 0) check_output("a_unexpected_out_valid", 64'(ov_a), 64'd0);
      else begin
        ea = qa.pop_front();
        check_output("a_sel", 64'(sel_a), ea.sel);
        check_output("a_valid_mask", 64'(vm_a), ea.mask);
        check_output("a_norm_event", 64'(ne_a), 64'(ea.norm));
        check_output("a_best_state", 64'(bs_a), 64'(ea.bs));
        check_output("a_best_metric", 64'(bm_a), 64'(ea.bmet));
      end
    end
  end

  always @(negedge clk) begin
    if (ov_b === 1'b1) begin
      if (qb.size() == 0) check_output("b_unexpected_out_valid", 64'(ov_b), 64'd0);
      else begin
        eb = qb.pop_front();
        check_output("b_sel", sel_b, eb.sel);
        check_output("b_valid_mask", vm_b, eb.mask);
        check_output("b_norm_event", 64'(ne_b), 64'(eb.norm));
        check_output("b_best_state", 64'(bs_b), 64'(eb.bs));
        check_output("b_best_metric", 64'(bm_b), 64'(eb.bmet[4:0]));
      end
    end
  end

  initial begin
    logic [1:0] d;
    logic [7:0] byte_v;
    logic [7:0] vm_tab [10];
    bit u;
    bit found;

    vm_tab = '{8'h11, 8'h55, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    model_reset(0);
    model_reset(1);
    enc_st = '{0, 0};
    eb_last = '0;
    eb_last.mask = 64'd1;

    // Power-on reset values.
    #1 rst = 1'b0;
    #10;
    check_output("rst_out_valid", 64'(ov_a), 64'd0);
    check_output("rst_valid_mask", 64'(vm_a), 64'h01);
    check_output("rst_sel", 64'(sel_a), 64'd0);
    check_output("rst_norm_event", 64'(ne_a), 64'd0);
    check_output("rst_best_state", 64'(bs_a), 64'd0);
    check_output("rst_best_metric", 64'(bm_a), 64'd0);
    check_output("rst_pm0", 64'(u_a.pm[0]), 64'd0);
    check_output("rst_pm1", 64'(u_a.pm[1]), 64'hFF);
    check_output("rst_b_valid_mask", vm_b, 64'd1);
    @(negedge clk);
    rst = 1'b1;

    // First step from reset with symbol 00.
    apply_stimulus(0, 2'b00);
    idle(0);
    check_output("step1_valid_mask", 64'(vm_a), 64'h11);
    check_output("step1_sel", 64'(sel_a), 64'h00);
    check_output("step1_pm0", 64'(u_a.pm[0]), 64'd0);
    check_output("step1_pm4", 64'(u_a.pm[4]), 64'd2);
    check_output("step1_best_state", 64'(bs_a), 64'd0);

    // All-zero stream: reachability fills out, best stays at state 0 with metric 0.
    reset_all();
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(0, 2'b00);
      @(posedge clk);
      #1;
      check_output("zeros_valid_mask", 64'(vm_a), 64'(vm_tab[k]));
      check_output("zeros_best_state", 64'(bs_a), 64'd0);
      check_output("zeros_best_metric", 64'(bm_a), 64'd0);
    end

    // Encoded 0x5A with a single bit error on symbol 3.
    reset_all();
    byte_v = 8'h5A;
    for (int b = 0; b < 8; b++) begin
      encode(0, byte_v[b], d);
      if (b == 3) d[0] = ~d[0];
      apply_stimulus(0, d);
      @(posedge clk);
      #1;
      check_output("enc_best_metric", 64'(bm_a), (BEST_EN && b >= 3) ? 64'd1 : 64'd0);
      if (b < 3) check_output("enc_best_state", 64'(bs_a), BEST_EN ? 64'(enc_st[0]) : 64'd0);
    end

    // One-cycle enable drop restarts the trellis and outranks in_valid.
    apply_stimulus(0, 2'b10);
    apply_stimulus(0, 2'b01);
    @(negedge clk);
    en_a = 1'b0; iv_a = 1'b1; d_a = 2'b11;
    model_reset(0);
    @(posedge clk);
    #1;
    check_output("en_low_out_valid", 64'(ov_a), 64'd0);
    check_output("en_low_valid_mask", 64'(vm_a), 64'h01);
    check_output("en_low_sel", 64'(sel_a), 64'd0);
    check_output("en_low_pm4", 64'(u_a.pm[4]), 64'hFF);
    apply_stimulus(0, 2'b00);
    idle(0);
    check_output("en_restart_valid_mask", 64'(vm_a), 64'h11);
    check_output("en_restart_pm4", 64'(u_a.pm[4]), 64'd2);

    // Asynchronous reset in the middle of an output cycle.
    apply_stimulus(0, 2'b11);
    @(posedge clk);
    #1;
    check_output("pre_arst_out_valid", 64'(ov_a), 64'd1);
    #2;
    rst = 1'b0;
    iv_a = 1'b0;
    #1;
    check_output("arst_out_valid", 64'(ov_a), 64'd0);
    check_output("arst_valid_mask", 64'(vm_a), 64'h01);
    check_output("arst_sel", 64'(sel_a), 64'd0);
    check_output("arst_norm_event", 64'(ne_a), 64'd0);
    check_output("arst_best_metric", 64'(bm_a), 64'd0);
    check_output("arst_pm0", 64'(u_a.pm[0]), 64'd0);
    qa.delete();
    qb.delete();
    model_reset(0);
    model_reset(1);
    enc_st = '{0, 0};
    eb_last = '0;
    eb_last.mask = 64'd1;
    @(negedge clk);
    rst = 1'b1;

    // K=7 stream with five bit errors and random in_valid gaps.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
        @(posedge clk);
        #1;
        check_output("gap_out_valid", 64'(ov_b), 64'd0);
        check_output("gap_valid_mask", vm_b, eb_last.mask);
        check_output("gap_sel", sel_b, eb_last.sel);
      end
      u = 1'($urandom_range(0, 1));
      encode(1, u, d);
      if (n == 17 || n == 53 || n == 99 || n == 140 || n == 181) d[1] = ~d[1];
      apply_stimulus(1, d);
    end

    // Random noise on the narrow-metric instance until normalisation fires.
    found = 1'b0;
    for (int n = 0; n < 3000 && !found; n++) begin
      apply_stimulus(1, 2'($urandom));
      if (eb_last.norm) found = 1'b1;
    end
    idle(1);
    if (found) begin
      for (int s = 0; s < 64; s++)
        check_output("norm_pm", 64'(u_b.pm[s]), 64'(mpm[1][s]));
    end
    check_output("norm_reached", 64'(found), 64'd1);

    repeat (3) @(negedge clk);
    check_output("qa_drained", 64'(qa.size()), 64'd0);
    check_output("qb_drained", 64'(qb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
